ll_update: RTL
==============

// Module: ll_update
// PURPOSE
//  Next-state engine for the lander; it is the writer side of the lander state register file.
//  - On each physics tick it reads current alt/vel/fuel/thrust and computes alt_n/vel_n/fuel_n/thrust_n.
//  - It presents them with a one-cycle wen pulse.
//  - All values are 16-bit, 4-digit BCD ten's-complement. A value is negative iff its MS digit >= 5.
//  - Arithmetic is digit-serial: one BCD digit per cycle, sharing a single digit adder.
//  - It detects touchdown and latches landed/crashed, after which it stops writing.
// PARAMETERS
//  GRAVITY   16'h0005  BCD magnitude subtracted from velocity every tick
//  SAFE_VEL  16'h9970  most negative velocity (-30) that still counts as a safe landing
// PORTS
//  clk        in   1   clock, all state updates on posedge
//  rst        in   1   synchronous, active-low reset (sampled on posedge clk)
//  tick       in   1   physics step request, 1-cycle pulse
//  alt        in   16  current altitude (BCD ten's-comp)
//  vel        in   16  current velocity (BCD ten's-comp, negative = falling)
//  fuel       in   16  current fuel (BCD, non-negative)
//  thrust     in   16  current thrust (BCD, non-negative)
//  thrust_in  in   16  requested thrust for next step; only digit 0 used, digit > 9 treated as 9
//  alt_n      out  16  next altitude
//  vel_n      out  16  next velocity
//  fuel_n     out  16  next fuel
//  thrust_n   out  16  next thrust
//  wen        out  1   write strobe to state register file, 1-cycle pulse
//  busy       out  1   computation in progress (state != IDLE)
//  landed     out  1   sticky: safe touchdown
//  crashed    out  1   sticky: unsafe touchdown
// BEHAVIOUR
//  Reset (rst==0 at posedge):
//   - state=IDLE; alt_n/vel_n/fuel_n/thrust_n=16'h0000; wen=busy=landed=crashed=0.
//   - Reset overrides any in-flight operation; no wen is emitted for it.
//  Digit adder: s = a + b + c.
//   - If s > 9: digit = s - 10, carry-out = 1; else digit = s, carry-out = 0.
//   - Digit 0 is processed first.
//   - Add uses c0 = 0. Subtract X-Y = X + nines(Y) with c0 = 1.
//   - The final carry is discarded (mod 10^4).
//  FSM states: IDLE, FUEL, VEL1, VEL2, ALT, CHECK, WRITE.
//   - FUEL, VEL1, VEL2 and ALT each take 4 cycles (digits 0..3).
//  IDLE:
//   - tick while landed|crashed is ignored.
//   - Otherwise tick captures alt, vel, fuel, thrust and thrust_in into operand registers, then goes to FUEL.
//  FUEL:  D = fuel - thrust.
//   - If D is negative: effective thrust T = fuel, fuel_n = 0000.
//   - Else: T = thrust, fuel_n = D.
//  VEL1:  V1 = vel + T.
//  VEL2:  vel_n = V1 - GRAVITY.
//  ALT:   alt_n = alt + vel (old vel); thrust_n = thrust_in low digit, zero-extended.
//  CHECK: if alt_n is negative or 0000 (touchdown):
//   - alt_n = 0000, vel_n = 0000, thrust_n = 0000.
//   - Old vel negative and vel < SAFE_VEL (ten's-comp compare): crashed = 1.
//   - Otherwise: landed = 1.
//  WRITE: wen = 1 for exactly this cycle, then IDLE.
//   - Outputs hold their values until the next WRITE.
//  Latency: tick accepted at cycle 0 -> wen high at cycle 18 -> IDLE at cycle 19.
//   - busy = 1 for cycles 1..18.
//  Overlap and termination:
//   - Ticks while busy are dropped, not queued.
//   - After landed/crashed, wen never asserts again until reset.
//   - landed and crashed are never both 1.
// TESTING
//  - Reset: rst=0 for 2 cycles -> all outputs 0; wen stays 0 for 30 idle cycles.
//  - Nominal: alt=4500 vel=0000 fuel=0800 thrust=0005 thrust_in=0007, tick
//    -> wen at cycle 18; fuel_n=0795 vel_n=0000 alt_n=4500 thrust_n=0007.
//  - Free fall: alt=4500 vel=0000 fuel=0800 thrust=0000, tick -> vel_n=9995.
//    Re-tick with vel=9995 -> alt_n=4495 vel_n=9990.
//  - Fuel out: fuel=0003 thrust=0005 vel=0000, tick -> fuel_n=0000 vel_n=9998.
//  - Touchdown: alt=0010 vel=9990 -> landed=1, alt_n=vel_n=0000, one wen, later ticks give no wen.
//    alt=0020 vel=9950 -> crashed=1.
//  - Robustness: second tick at cycle 5 is ignored (single wen at cycle 18).
//    rst=0 at cycle 10 -> no wen, busy=0 next cycle.

Source files
------------

// File: rtl/ll_update.sv
// Lander next-state engine: digit-serial BCD ten's-complement update of alt/vel/fuel/thrust per tick.
// Latency: tick at cycle 0 -> wen pulse at cycle 18 -> idle at cycle 19; ticks while busy or after touchdown are dropped.
module ll_update #(
    parameter logic [15:0] GRAVITY  = 16'h0005,
    parameter logic [15:0] SAFE_VEL = 16'h9970
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [15:0] alt,
    input  logic [15:0] vel,
    input  logic [15:0] fuel,
    input  logic [15:0] thrust,
    input  logic [15:0] thrust_in,
    output logic [15:0] alt_n,
    output logic [15:0] vel_n,
    output logic [15:0] fuel_n,
    output logic [15:0] thrust_n,
    output logic        wen,
    output logic        busy,
    output logic        landed,
    output logic        crashed
);

    typedef enum logic [2:0] {IDLE, FUEL, VEL1, VEL2, ALT, CHECK, WRITE} state_t;

    state_t      state, state_nx;
    logic [1:0]  cnt;
    logic        carry;
    logic [15:0] op_alt, op_vel, op_fuel, op_thr;
    logic [3:0]  op_tin;
    logic [15:0] r_fuel, r_vel, r_alt;

    logic [3:0]  sh;
    logic [3:0]  a_dig, b_dig, sum_dig;
    logic        c0, cin, cout;
    logic [4:0]  sum;
    logic        fuel_neg, touchdown, too_fast;
    logic [15:0] t_eff;
    logic        accept;

    assign sh        = {cnt, 2'b00};
    assign fuel_neg  = (r_fuel[15:12] >= 4'd5);
    assign t_eff     = fuel_neg ? op_fuel : op_thr;
    assign touchdown = (r_alt[15:12] >= 4'd5) || (r_alt == 16'h0000);
    // Both operands are negative here, so raw BCD order matches numeric order.
    assign too_fast  = (op_vel[15:12] >= 4'd5) && (op_vel < SAFE_VEL);
    assign accept    = tick && !(landed || crashed);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = FUEL;
            FUEL:    if (cnt == 2'd3) state_nx = VEL1;
            VEL1:    if (cnt == 2'd3) state_nx = VEL2;
            VEL2:    if (cnt == 2'd3) state_nx = ALT;
            ALT:     if (cnt == 2'd3) state_nx = CHECK;
            CHECK:   state_nx = WRITE;
            WRITE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        wen  = (state == WRITE);
        busy = (state != IDLE);
    end

    // Shared digit adder; subtraction feeds the nines complement with c0 = 1
    always_comb begin
        a_dig = 4'd0;
        b_dig = 4'd0;
        c0    = 1'b0;
        case (state)
            FUEL: begin
                a_dig = op_fuel[sh +: 4];
                b_dig = 4'd9 - op_thr[sh +: 4];
                c0    = 1'b1;
            end
            VEL1: begin
                a_dig = op_vel[sh +: 4];
                b_dig = t_eff[sh +: 4];
            end
            VEL2: begin
                a_dig = r_vel[sh +: 4];
                b_dig = 4'd9 - GRAVITY[sh +: 4];
                c0    = 1'b1;
            end
            ALT: begin
                a_dig = op_alt[sh +: 4];
                b_dig = op_vel[sh +: 4];
            end
            default: ;
        endcase
        cin  = (cnt == 2'd0) ? c0 : carry;
        sum  = {1'b0, a_dig} + {1'b0, b_dig} + {4'd0, cin};
        cout = (sum > 5'd9);
        sum_dig = cout ? 4'(sum - 5'd10) : sum[3:0];
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= 2'd0;
            carry    <= 1'b0;
            op_alt   <= 16'h0000;
            op_vel   <= 16'h0000;
            op_fuel  <= 16'h0000;
            op_thr   <= 16'h0000;
            op_tin   <= 4'd0;
            r_fuel   <= 16'h0000;
            r_vel    <= 16'h0000;
            r_alt    <= 16'h0000;
            alt_n    <= 16'h0000;
            vel_n    <= 16'h0000;
            fuel_n   <= 16'h0000;
            thrust_n <= 16'h0000;
            landed   <= 1'b0;
            crashed  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= 2'd0;
                    if (accept) begin
                        op_alt  <= alt;
                        op_vel  <= vel;
                        op_fuel <= fuel;
                        op_thr  <= thrust;
                        op_tin  <= (thrust_in[3:0] > 4'd9) ? 4'd9 : thrust_in[3:0];
                    end
                end
                FUEL, VEL1, VEL2, ALT: begin
                    cnt   <= cnt + 2'd1;
                    carry <= cout;
                    case (state)
                        FUEL:    r_fuel[sh +: 4] <= sum_dig;
                        ALT:     r_alt[sh +: 4]  <= sum_dig;
                        default: r_vel[sh +: 4]  <= sum_dig;
                    endcase
                end
                CHECK: begin
                    fuel_n <= fuel_neg ? 16'h0000 : r_fuel;
                    if (touchdown) begin
                        alt_n    <= 16'h0000;
                        vel_n    <= 16'h0000;
                        thrust_n <= 16'h0000;
                        if (too_fast) crashed <= 1'b1;
                        else          landed  <= 1'b1;
                    end else begin
                        alt_n    <= r_alt;
                        vel_n    <= r_vel;
                        thrust_n <= {12'h000, op_tin};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
